// File: rtl/cache_pkg.sv
// Shared constants and encodings for the cache / main-memory subsystem.
// Block addresses exclude the two word-offset bits; one block is four 32-bit words.
package cache_pkg;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        CLI_I = 1'b0,
        CLI_D = 1'b1
    } client_e;

    // Watchdog counter width; a disabled watchdog (timeout 0) still keeps a 1-bit counter.
    function automatic int wd_cnt_width(input int timeout);
        if (timeout > 0) begin
            return $clog2(timeout + 1);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-client arbiter for the shared 128-bit main-memory port (I-cache read-only, D-cache read/write-back).
// One client owns the port per transaction; ties alternate; a sticky watchdog flags a silent memory.
module mem_arbiter
    import cache_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err
);

    localparam int CNT_W = wd_cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    // err is raised on the edge where the count becomes TIMEOUT, i.e. while it still reads TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic             WD_EN    = (TIMEOUT > 0) ? 1'b1 : 1'b0;

    arb_state_e        state_q, state_d;
    client_e           last_q,  last_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              err_q,   err_d;

    logic i_req_s;
    logic d_req_s;
    logic in_grant_s;

    assign i_req_s    = i_read;
    assign d_req_s    = d_read | d_write;
    assign in_grant_s = (state_q == ST_GNT_I) || (state_q == ST_GNT_D);

    // Next-state logic: arbitration in IDLE, completion and watchdog counting in a grant.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (i_req_s && d_req_s) begin
                    if (last_q == CLI_D) begin
                        state_d = ST_GNT_I;
                    end else begin
                        state_d = ST_GNT_D;
                    end
                end else if (i_req_s) begin
                    state_d = ST_GNT_I;
                end else if (d_req_s) begin
                    state_d = ST_GNT_D;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GNT_I: begin
                if (mem_ready) begin
                    state_d = ST_IDLE;
                    last_d  = CLI_I;
                end else begin
                    state_d = ST_GNT_I;
                end
            end
            ST_GNT_D: begin
                if (mem_ready) begin
                    state_d = ST_IDLE;
                    last_d  = CLI_D;
                end else begin
                    state_d = ST_GNT_D;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (in_grant_s) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
            if (WD_EN && (cnt_q >= CNT_LAST)) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
        end else begin
            err_d = err_q;
        end
    end

    // State registers; reset abandons any in-flight transaction and lets I win the first tie.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q <= ST_IDLE;
            last_q  <= CLI_D;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Memory port and ready routing follow the current owner combinationally.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_ready   = 1'b0;
        d_ready   = 1'b0;
        case (state_q)
            ST_GNT_I: begin
                mem_read = i_read;
                mem_addr = i_addr;
                i_ready  = mem_ready;
            end
            ST_GNT_D: begin
                mem_read  = d_read;
                mem_write = d_write;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_ready   = mem_ready;
            end
            default: begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
        endcase
    end

    assign rdata = mem_rdata;
    assign err   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a short watchdog (TIMEOUT = 8).
module tb_mem_arbiter;
    import cache_pkg::*;

    logic              clk = 1'b0;
    logic              proc_reset = 1'b1;
    logic              i_read = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic              i_ready;
    logic              d_read = 1'b0;
    logic              d_write = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_ready;
    logic [DATA_W-1:0] rdata;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ready = 1'b0;
    logic              err;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .proc_reset(proc_reset),
        .i_read(i_read), .i_addr(i_addr), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready),
        .rdata(rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2;
        proc_reset = 1'b1;
        #1;
        proc_reset = 1'b0;
    endtask

    // One arbitration round with both clients requesting; owner_d selects the expected winner.
    task automatic round(input logic owner_d, input string tag);
        step();
        chk({tag, "_read"}, 128'(mem_read), 128'(1'b1));
        chk({tag, "_addr"}, 128'(mem_addr), owner_d ? 128'(28'h0000200) : 128'(28'h0000100));
        mem_ready = 1'b1;
        #1;
        chk({tag, "_i_ready"}, 128'(i_ready), 128'(!owner_d));
        chk({tag, "_d_ready"}, 128'(d_ready), 128'(owner_d));
        step();
        mem_ready = 1'b0;
        #1;
        chk({tag, "_idle_gap"}, 128'(mem_read), 128'(1'b0));
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_mem_read", 128'(mem_read), 128'(1'b0));
        chk("rst_mem_write", 128'(mem_write), 128'(1'b0));
        chk("rst_ready", 128'({i_ready, d_ready}), 128'(2'b00));
        chk("rst_err", 128'(err), 128'(1'b0));
        chk("rst_addr", 128'(mem_addr), 128'(28'h0));
        step();
        proc_reset = 1'b0;

        // 1. I only, memory answers on the third grant cycle
        i_read = 1'b1;
        i_addr = 28'h0000010;
        #1;
        chk("t1_idle_read", 128'(mem_read), 128'(1'b0));
        step();
        chk("t1_c1_read", 128'(mem_read), 128'(1'b1));
        chk("t1_c1_addr", 128'(mem_addr), 128'(28'h10));
        chk("t1_c1_iready", 128'(i_ready), 128'(1'b0));
        step();
        chk("t1_c2_read", 128'(mem_read), 128'(1'b1));
        step();
        chk("t1_c3_addr", 128'(mem_addr), 128'(28'h10));
        mem_ready = 1'b1;
        mem_rdata = {4{32'hA5A5A5A5}};
        #1;
        chk("t1_iready", 128'(i_ready), 128'(1'b1));
        chk("t1_dready", 128'(d_ready), 128'(1'b0));
        chk("t1_rdata", rdata, {4{32'hA5A5A5A5}});
        step();
        i_read = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("t1_done_read", 128'(mem_read), 128'(1'b0));
        chk("t1_done_iready", 128'(i_ready), 128'(1'b0));

        // 2. Ties after reset alternate starting with I
        pulse_reset();
        i_addr = 28'h0000100;
        d_addr = 28'h0000200;
        i_read = 1'b1;
        d_read = 1'b1;
        round(1'b0, "t2_r1");
        round(1'b1, "t2_r2");
        round(1'b0, "t2_r3");
        round(1'b1, "t2_r4");
        i_read = 1'b0;
        d_read = 1'b0;

        // 3. D write-back followed by allocate
        d_write = 1'b1;
        d_addr  = 28'h0000020;
        d_wdata = {4{32'h12345678}};
        step();
        chk("t3_wb_write", 128'(mem_write), 128'(1'b1));
        chk("t3_wb_read", 128'(mem_read), 128'(1'b0));
        chk("t3_wb_addr", 128'(mem_addr), 128'(28'h20));
        chk("t3_wb_wdata", mem_wdata, {4{32'h12345678}});
        mem_ready = 1'b1;
        #1;
        chk("t3_wb_dready", 128'(d_ready), 128'(1'b1));
        step();
        mem_ready = 1'b0;
        d_write = 1'b0;
        d_read  = 1'b1;
        d_addr  = 28'h0000030;
        #1;
        chk("t3_gap_rw", 128'({mem_read, mem_write}), 128'(2'b00));
        chk("t3_gap_wdata", mem_wdata, 128'h0);
        step();
        chk("t3_al_rw", 128'({mem_read, mem_write}), 128'(2'b10));
        chk("t3_al_addr", 128'(mem_addr), 128'(28'h30));
        mem_ready = 1'b1;
        #1;
        chk("t3_al_dready", 128'(d_ready), 128'(1'b1));
        step();
        mem_ready = 1'b0;
        d_read = 1'b0;

        // 4. I requests while D owns the port
        d_read = 1'b1;
        d_addr = 28'h0000040;
        step();
        i_read = 1'b1;
        i_addr = 28'h0000050;
        #1;
        chk("t4_owner_addr", 128'(mem_addr), 128'(28'h40));
        mem_ready = 1'b1;
        #1;
        chk("t4_dready", 128'(d_ready), 128'(1'b1));
        chk("t4_iready", 128'(i_ready), 128'(1'b0));
        chk("t4_addr_ready", 128'(mem_addr), 128'(28'h40));
        step();
        mem_ready = 1'b0;
        d_read = 1'b0;
        #1;
        chk("t4_idle_read", 128'(mem_read), 128'(1'b0));
        step();
        chk("t4_i_addr", 128'(mem_addr), 128'(28'h50));
        mem_ready = 1'b1;
        #1;
        chk("t4_i_ready", 128'(i_ready), 128'(1'b1));
        step();
        mem_ready = 1'b0;
        i_read = 1'b0;

        // 5. Watchdog with a silent memory
        i_read = 1'b1;
        i_addr = 28'h0000070;
        step();
        chk("t5_grant_err", 128'(err), 128'(1'b0));
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("t5_err_c%0d", k), 128'(err), 128'(1'b0));
        end
        step();
        chk("t5_err_c8", 128'(err), 128'(1'b1));
        chk("t5_still_granted", 128'(mem_read), 128'(1'b1));
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        i_read = 1'b0;
        #1;
        chk("t5_err_sticky", 128'(err), 128'(1'b1));
        step();
        chk("t5_err_sticky2", 128'(err), 128'(1'b1));
        pulse_reset();
        chk("t5_err_cleared", 128'(err), 128'(1'b0));

        // 6. Asynchronous reset in the middle of a grant
        i_read = 1'b1;
        i_addr = 28'h0000060;
        step();
        chk("t6_granted", 128'(mem_read), 128'(1'b1));
        d_read = 1'b1;
        d_addr = 28'h0000090;
        mem_ready = 1'b1;
        #2;
        proc_reset = 1'b1;
        #1;
        chk("t6_async_read", 128'(mem_read), 128'(1'b0));
        chk("t6_async_ready", 128'({i_ready, d_ready}), 128'(2'b00));
        mem_ready = 1'b0;
        #1;
        proc_reset = 1'b0;
        step();
        chk("t6_tie_owner", 128'(mem_addr), 128'(28'h60));
        chk("t6_tie_read", 128'(mem_read), 128'(1'b1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
